// File: rtl/tx_link_pkg.sv
// Shared types, default parameters and a width helper for the transmit link scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package tx_link_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XMIT = 2'd1,
      GAP  = 2'd2
   } link_state_t;

   localparam int DEF_N_REQ     = 4;
   localparam int DEF_TIMEOUT   = 8;
   localparam int DEF_MAX_RETRY = 2;

   // $clog2 that never returns 0, so a counter for range 0..0 still gets one bit.
   function automatic int clog2_min1(input int v);
      return (v <= 2) ? 1 : $clog2(v);
   endfunction

endpackage

// File: rtl/tx_link_scheduler_arbiter.sv
// Round-robin pick: first set req at or after ptr, wrapping modulo N.
// Latency: purely combinational.
// Backpressure: none; valid low when no request is pending.
// Ports: req (request vector), ptr (search start), winner (index), valid (any request).
module rr_arbiter
   import tx_link_pkg::*;
#(
   parameter int N = DEF_N_REQ
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] ptr,
   output logic [$clog2(N)-1:0] winner,
   output logic                 valid
);

   localparam int W = $clog2(N);

   // One extra bit so ptr + i cannot overflow before the explicit wrap,
   // which keeps non-power-of-two N correct.
   logic [W:0] cand;

   always_comb begin
      winner = '0;
      valid  = 1'b0;
      cand   = '0;
      for (int i = 0; i < N; i++) begin
         cand = {1'b0, ptr} + (W+1)'(i);
         if (cand >= (W+1)'(N)) begin
            cand = cand - (W+1)'(N);
         end
         if (!valid && req[cand[W-1:0]]) begin
            valid  = 1'b1;
            winner = cand[W-1:0];
         end
      end
   end

endmodule

// File: rtl/tx_link_scheduler.sv
// Shares one transmitter->receiver link among N_REQ requesters with round-robin grant, timeout and bounded retry.
// Latency: grant/transmiter one edge after req is seen in IDLE; done/err registered one edge after ack/final timeout.
// Backpressure: level req held by requesters; link held until ack or retries exhausted, 1-cycle GAP between attempts.
// Ports: clk, rst (sync, active-high); req[N_REQ] in; recevier (ack) in;
//        grant[N_REQ] one-hot owner, transmiter, done/err pulses, busy, spurious_ack (sticky) out.
module tx_link_scheduler
   import tx_link_pkg::*;
#(
   parameter int N_REQ     = DEF_N_REQ,
   parameter int TIMEOUT   = DEF_TIMEOUT,
   parameter int MAX_RETRY = DEF_MAX_RETRY
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_REQ-1:0] req,
   input  logic             recevier,
   output logic [N_REQ-1:0] grant,
   output logic             transmiter,
   output logic [N_REQ-1:0] done,
   output logic [N_REQ-1:0] err,
   output logic             busy,
   output logic             spurious_ack
);

   localparam int RR_W = $clog2(N_REQ);
   localparam int TC_W = $clog2(TIMEOUT);
   localparam int RT_W = clog2_min1(MAX_RETRY + 1);

   link_state_t     state;
   logic [RR_W-1:0] rr;
   logic [RR_W-1:0] owner;
   logic [TC_W-1:0] tcnt;
   logic [RT_W-1:0] retries;
   logic            retry_pending;

   logic [RR_W-1:0] arb_win;
   logic            arb_vld;
   logic [RR_W-1:0] next_rr;

   rr_arbiter #(.N(N_REQ)) u_arb (
      .req    (req),
      .ptr    (rr),
      .winner (arb_win),
      .valid  (arb_vld)
   );

   // Explicit wrap: N_REQ need not be a power of two.
   assign next_rr = (owner == RR_W'(N_REQ - 1)) ? '0 : owner + RR_W'(1);

   function automatic logic [N_REQ-1:0] onehot(input logic [RR_W-1:0] idx);
      logic [N_REQ-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         rr            <= '0;
         owner         <= '0;
         tcnt          <= '0;
         retries       <= '0;
         retry_pending <= 1'b0;
         grant         <= '0;
         transmiter    <= 1'b0;
         done          <= '0;
         err           <= '0;
         busy          <= 1'b0;
         spurious_ack  <= 1'b0;
      end else begin
         done <= '0;
         err  <= '0;

         // An ack outside a transmit window only flags; it never steers the FSM.
         if (recevier && state != XMIT) begin
            spurious_ack <= 1'b1;
         end

         case (state)
            XMIT: begin
               if (recevier) begin
                  // Ack wins over a coincident timeout.
                  done          <= onehot(owner);
                  grant         <= '0;
                  transmiter    <= 1'b0;
                  retry_pending <= 1'b0;
                  rr            <= next_rr;
                  state         <= GAP;
               end else if (tcnt == TC_W'(TIMEOUT - 1)) begin
                  grant      <= '0;
                  transmiter <= 1'b0;
                  state      <= GAP;
                  if (retries < RT_W'(MAX_RETRY)) begin
                     retries       <= retries + RT_W'(1);
                     retry_pending <= 1'b1;
                  end else begin
                     err           <= onehot(owner);
                     retry_pending <= 1'b0;
                     rr            <= next_rr;
                  end
               end else begin
                  tcnt <= tcnt + TC_W'(1);
               end
            end

            IDLE, GAP: begin
               if (state == GAP && retry_pending) begin
                  // Retry the same owner without re-arbitrating.
                  retry_pending <= 1'b0;
                  grant         <= onehot(owner);
                  transmiter    <= 1'b1;
                  tcnt          <= '0;
                  state         <= XMIT;
               end else if (arb_vld) begin
                  // Arbitrating straight out of GAP gives the 1-cycle minimum gap.
                  owner      <= arb_win;
                  grant      <= onehot(arb_win);
                  transmiter <= 1'b1;
                  busy       <= 1'b1;
                  tcnt       <= '0;
                  retries    <= '0;
                  state      <= XMIT;
               end else begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end

            default: begin
               grant      <= '0;
               transmiter <= 1'b0;
               busy       <= 1'b0;
               state      <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tx_link_scheduler.sv
// Directed bench for tx_link_scheduler with hand-computed expectations.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_tx_link_scheduler;

   localparam int N  = 4;
   localparam int TO = 8;
   localparam int MR = 2;

   logic         clk;
   logic         rst;
   logic [N-1:0] req;
   logic         recevier;
   logic [N-1:0] grant;
   logic         transmiter;
   logic [N-1:0] done;
   logic [N-1:0] err;
   logic         busy;
   logic         spurious_ack;

   int checks   = 0;
   int errors   = 0;
   int inv_viol = 0;
   int thr_viol = 0;
   int win      = 0;
   int hi       = 0;
   logic mon_en  = 1'b0;
   logic prev_tx = 1'b0;
   logic prev_rcv = 1'b0;
   logic prev_rst = 1'b0;

   int exp_order [5] = '{0, 1, 2, 3, 0};

   tx_link_scheduler #(.N_REQ(N), .TIMEOUT(TO), .MAX_RETRY(MR)) dut (
      .clk          (clk),
      .rst          (rst),
      .req          (req),
      .recevier     (recevier),
      .grant        (grant),
      .transmiter   (transmiter),
      .done         (done),
      .err          (err),
      .busy         (busy),
      .spurious_ack (spurious_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
      checks++;
      if (got !== expv) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      req      = '0;
      recevier = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   // Invariant and "transmiter held until ack or full timeout window" monitor,
   // sampled on the falling edge. Inputs change just after posedge, so values
   // seen at a negedge are the ones the following posedge samples.
   always @(negedge clk) begin
      if (mon_en) begin
         if ((grant & (grant - 4'd1)) != 4'd0 || transmiter != (|grant) ||
             (done & err) != 4'd0 || $countones(done) > 1 || $countones(err) > 1) begin
            inv_viol <= inv_viol + 1;
         end
         if (transmiter) begin
            win <= win + 1;
            if (win + 1 > TO) thr_viol <= thr_viol + 1;
         end else begin
            if (prev_tx && win != TO && !prev_rcv && !prev_rst) thr_viol <= thr_viol + 1;
            win <= 0;
         end
      end
      prev_tx  <= transmiter;
      prev_rcv <= recevier;
      prev_rst <= rst;
   end

   initial begin
      #100000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst      = 1'b1;
      req      = '0;
      recevier = 1'b0;
      tick();  // reset applied at t=5
      mon_en = 1'b1;
      check("rst_grant", 32'(grant), 0);
      check("rst_tx", 32'(transmiter), 0);
      check("rst_done", 32'(done), 0);
      check("rst_err", 32'(err), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_spur", 32'(spurious_ack), 0);

      // Spurious ack sampled at t=15 while IDLE.
      rst      = 1'b0;
      recevier = 1'b1;
      tick();
      recevier = 1'b0;
      check("t5_spur", 32'(spurious_ack), 1);
      check("t5_grant", 32'(grant), 0);
      check("t5_busy", 32'(busy), 0);
      tick();
      tick();
      check("t5_spur_sticky", 32'(spurious_ack), 1);
      check("t5_grant_late", 32'(grant), 0);
      do_reset();
      check("t5_spur_clr", 32'(spurious_ack), 0);

      // Single transfer, ack two cycles after transmiter rises.
      req = 4'b0001;
      tick();
      check("t1_grant", 32'(grant), 1);
      check("t1_tx", 32'(transmiter), 1);
      tick();
      check("t1_tx2", 32'(transmiter), 1);
      recevier = 1'b1;
      req      = '0;
      tick();
      recevier = 1'b0;
      check("t1_done", 32'(done), 1);
      check("t1_gap_grant", 32'(grant), 0);
      check("t1_gap_busy", 32'(busy), 1);
      tick();
      check("t1_idle_busy", 32'(busy), 0);
      check("t1_done_off", 32'(done), 0);
      check("t1_spur", 32'(spurious_ack), 0);

      // Round-robin order with all requesters active.
      do_reset();
      req = 4'b1111;
      tick();
      for (int i = 0; i < 5; i++) begin
         check("t2_grant", 32'(grant), 32'(1) << exp_order[i]);
         recevier = 1'b1;
         tick();
         recevier = 1'b0;
         if (i == 4) req = '0;
         check("t2_gap_grant", 32'(grant), 0);
         check("t2_done", 32'(done), 32'(1) << exp_order[i]);
         tick();
      end
      check("t2_end_busy", 32'(busy), 0);

      // Ack on the timeout edge: done, no retry, no err.
      do_reset();
      req = 4'b0001;
      tick();
      check("t4_grant", 32'(grant), 1);
      for (int c = 0; c < 7; c++) tick();
      check("t4_tx_last", 32'(transmiter), 1);
      recevier = 1'b1;
      req      = '0;
      tick();
      recevier = 1'b0;
      check("t4_done", 32'(done), 1);
      check("t4_err", 32'(err), 0);
      check("t4_tx_off", 32'(transmiter), 0);
      tick();
      check("t4_no_retry", 32'(transmiter), 0);
      check("t4_busy", 32'(busy), 0);
      check("t4_err2", 32'(err), 0);
      check("t4_spur", 32'(spurious_ack), 0);

      // No ack ever: three full windows, then one err pulse.
      do_reset();
      req = 4'b0100;
      hi  = 0;
      tick();
      for (int a = 0; a < 3; a++) begin
         check("t3_grant", 32'(grant), 4);
         for (int c = 0; c < 7; c++) begin
            if (transmiter) hi++;
            tick();
         end
         if (transmiter) hi++;
         if (a == 2) req = '0;
         tick();
         check("t3_gap_tx", 32'(transmiter), 0);
         check("t3_err", 32'(err), (a == 2) ? 4 : 0);
         check("t3_done", 32'(done), 0);
         tick();
      end
      check("t3_tx_cycles", 32'(hi), 24);
      check("t3_err_once", 32'(err), 0);
      check("t3_idle", 32'(busy), 0);
      check("t3_grant_end", 32'(grant), 0);

      // Reset mid-transfer after rr has advanced to 2.
      do_reset();
      req = 4'b0010;
      tick();
      check("t6_grant1", 32'(grant), 2);
      recevier = 1'b1;
      tick();
      recevier = 1'b0;
      req      = '0;
      tick();
      req = 4'b0100;
      tick();
      check("t6_grant2", 32'(grant), 4);
      tick();
      rst = 1'b1;
      tick();
      check("t6_rst_grant", 32'(grant), 0);
      check("t6_rst_tx", 32'(transmiter), 0);
      check("t6_rst_busy", 32'(busy), 0);
      check("t6_rst_done", 32'(done), 0);
      check("t6_rst_err", 32'(err), 0);
      rst = 1'b0;
      req = 4'b1001;
      tick();
      check("t6_rr0_grant", 32'(grant), 1);
      check("t6_no_done", 32'(done), 0);
      check("t6_no_err", 32'(err), 0);
      req = '0;
      recevier = 1'b1;
      tick();
      recevier = 1'b0;
      tick();
      tick();

      check("invariants", 32'(inv_viol), 0);
      check("tx_throughout", 32'(thr_viol), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
